// File: rtl/word_tx_sched_pkg.sv
// word_tx_sched_pkg: shared types and defaults for the word transmit scheduler.
//
// Contents
//   state_t             scheduler FSM states (IDLE, ISSUE, GAP)
//   DEFAULT_FIFO_DEPTH  default byte FIFO depth used by word_tx_sched
package word_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

    localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/word_tx_sched_word_2_byte.sv
// word_2_byte: serialises one 16-bit word into two bytes, low byte first.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   word_dv  in   word strobe (one cycle)
//   word     in   16-bit word, sampled when word_dv=1
//   byte_dv  out  byte strobe, high for the two cycles after word_dv
//   byteee   out  byte: word[7:0] in the first cycle, word[15:8] in the second
//
// Word strobes must be at least three cycles apart so the high byte is out
// before the next word arrives.
module word_2_byte (
    input  logic        clk,
    input  logic        rst,
    input  logic        word_dv,
    input  logic [15:0] word,
    output logic        byte_dv,
    output logic [7:0]  byteee
);

    logic       byte_dv_q, byte_dv_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] hi_q, hi_d;
    logic       hi_pend_q, hi_pend_d;

    always_comb begin
        byte_dv_d = word_dv | hi_pend_q;
        byte_d    = word_dv ? word[7:0] : (hi_pend_q ? hi_q : byte_q);
        hi_d      = word_dv ? word[15:8] : hi_q;
        hi_pend_d = word_dv;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_dv_q <= 1'b0;
            byte_q    <= 8'd0;
            hi_q      <= 8'd0;
            hi_pend_q <= 1'b0;
        end else begin
            byte_dv_q <= byte_dv_d;
            byte_q    <= byte_d;
            hi_q      <= hi_d;
            hi_pend_q <= hi_pend_d;
        end
    end

    assign byte_dv = byte_dv_q;
    assign byteee  = byte_q;

endmodule

// File: rtl/word_tx_sched.sv
// word_tx_sched: arbitrates two word requesters onto one word_2_byte serialiser
// and queues the resulting bytes in a first-word-fall-through FIFO.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   ce          in   enables new grants (in-flight traffic is unaffected)
//   req0/word0  in   requester 0 valid / word, held until ack0
//   ack0        out  one-cycle accept pulse for requester 0
//   req1/word1  in   requester 1 valid / word, held until ack1
//   ack1        out  one-cycle accept pulse for requester 1
//   out_byte    out  FIFO head byte (0 while empty)
//   out_valid   out  FIFO not empty
//   out_rd      in   pop FIFO head (ignored while empty)
//   busy        out  scheduler active, FIFO non-empty or bytes in flight
//   words_sent  out  accepted-word counter, wraps
module word_tx_sched
    import word_tx_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        req0,
    input  logic [15:0] word0,
    output logic        ack0,
    input  logic        req1,
    input  logic [15:0] word1,
    output logic        ack1,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_rd,
    output logic        busy,
    output logic [15:0] words_sent
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // A grant needs room for both bytes of the word on top of what is
    // already queued or still on its way from the serialiser.
    localparam logic [CW:0] GRANT_LIMIT = (CW + 1)'(FIFO_DEPTH - 2);

    state_t      state_q;
    logic        last_grant_q;
    logic        ack0_q, ack1_q, word_dv_q;
    logic [15:0] word_q;
    logic [15:0] words_sent_q;

    logic [1:0]    rsv_q, rsv_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic       byte_dv;
    logic [7:0] byte_w;
    logic       push, pop, grant, grant_1;

    word_2_byte u_w2b (
        .clk     (clk),
        .rst     (rst),
        .word_dv (word_dv_q),
        .word    (word_q),
        .byte_dv (byte_dv),
        .byteee  (byte_w)
    );

    assign push = byte_dv;
    assign pop  = out_rd && (count_q != '0);

    // On a tie the requester that did not win last time gets the grant.
    assign grant_1 = (req0 && req1) ? ~last_grant_q : req1;
    assign grant   = (state_q == IDLE) && ce && (req0 || req1) &&
                     (({1'b0, count_q} + (CW + 1)'(rsv_q)) <= GRANT_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            word_dv_q    <= 1'b0;
            word_q       <= 16'd0;
            words_sent_q <= 16'd0;
        end else begin
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            word_dv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q      <= ISSUE;
                        word_dv_q    <= 1'b1;
                        ack0_q       <= ~grant_1;
                        ack1_q       <= grant_1;
                        word_q       <= grant_1 ? word1 : word0;
                        last_grant_q <= grant_1;
                    end
                end
                ISSUE: begin
                    state_q      <= GAP;
                    words_sent_q <= words_sent_q + 16'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reserved slots: two per granted word, released one per byte pushed.
    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        rsv_d    = rsv_q + (grant ? 2'd2 : 2'd0) - {1'b0, push};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rsv_q    <= 2'd0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rsv_q    <= rsv_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= byte_w;
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign out_valid  = count_q != '0;
    assign out_byte   = out_valid ? mem_q[rd_ptr_q] : 8'd0;
    assign busy       = (state_q != IDLE) || (count_q != '0) || (rsv_q != 2'd0);
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_word_tx_sched.sv
// tb_word_tx_sched: self-checking bench for word_tx_sched with a cycle model.
module tb_word_tx_sched;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        req0 = 1'b0;
    logic [15:0] word0 = 16'd0;
    logic        ack0;
    logic        req1 = 1'b0;
    logic [15:0] word1 = 16'd0;
    logic        ack1;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_rd = 1'b0;
    logic        busy;
    logic [15:0] words_sent;

    int checks = 0;
    int errors = 0;

    word_tx_sched #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .req0       (req0),
        .word0      (word0),
        .ack0       (ack0),
        .req1       (req1),
        .word1      (word1),
        .ack1       (ack1),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_rd     (out_rd),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    // Requester agents: each presents the head of its queue until accepted.
    logic [15:0] w0q[$];
    logic [15:0] w1q[$];

    always @(posedge clk) begin
        #2;
        req0  = w0q.size() > 0;
        word0 = req0 ? w0q[0] : 16'd0;
        req1  = w1q.size() > 0;
        word1 = req1 ? w1q[0] : 16'd0;
    end

    // Behavioural model: words are issued at least 3 cycles apart, each one
    // schedules its low byte 2 cycles and its high byte 3 cycles after the
    // grant decision; the FIFO is a plain queue.
    typedef struct {
        int         due;
        logic [7:0] b;
    } pend_t;

    logic [7:0]  m_fifo[$];
    pend_t       m_pend[$];
    int          m_cyc;
    int          m_last_issue;
    logic        m_last_who;
    logic        m_issue_now;
    logic        m_who;
    logic [15:0] m_words;

    logic        g_ok, g_who;
    logic [15:0] g_word;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            m_pend.delete();
            m_cyc        = 0;
            m_last_issue = -100;
            m_last_who   = 1'b1;
            m_issue_now  = 1'b0;
            m_who        = 1'b0;
            m_words      = 16'd0;
        end else begin
            g_ok   = (m_cyc - m_last_issue >= 2) && ce && (req0 || req1) &&
                     (m_fifo.size() + m_pend.size() <= DEPTH - 2);
            g_who  = (req0 && req1) ? !m_last_who : req1;
            g_word = g_who ? word1 : word0;
            if (out_rd && m_fifo.size() > 0) void'(m_fifo.pop_front());
            while (m_pend.size() > 0 && m_pend[0].due == m_cyc) m_fifo.push_back(m_pend.pop_front().b);
            if (m_issue_now) begin
                m_words = m_words + 16'd1;
                if (m_who && w1q.size() > 0) void'(w1q.pop_front());
                if (!m_who && w0q.size() > 0) void'(w0q.pop_front());
            end
            m_issue_now = 1'b0;
            if (g_ok) begin
                m_issue_now  = 1'b1;
                m_who        = g_who;
                m_last_who   = g_who;
                m_last_issue = m_cyc + 1;
                m_pend.push_back('{due: m_cyc + 2, b: g_word[7:0]});
                m_pend.push_back('{due: m_cyc + 3, b: g_word[15:8]});
            end
            m_cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic e_valid, e_idle;
        e_valid = m_fifo.size() > 0;
        e_idle  = (m_cyc - m_last_issue) >= 2;
        chk("ack0", ack0, m_issue_now && !m_who);
        chk("ack1", ack1, m_issue_now && m_who);
        chk("out_valid", out_valid, e_valid);
        if (e_valid) chk("out_byte", out_byte, m_fifo[0]);
        chk("busy", busy, !e_idle || e_valid || m_pend.size() > 0);
        chk("words_sent", words_sent, m_words);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic who, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(who ? ack1 : ack0) && k < 20);
    endtask

    task automatic count_acks(input int n, input logic who, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (who ? ack1 : ack0) c++;
        end
    endtask

    task automatic drain(input string name);
        int i = 0;
        while ((busy || w0q.size() > 0 || w1q.size() > 0) && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk(name, i < 100, 1);
    endtask

    task automatic pulse_rd();
        step();
        out_rd = 1'b1;
        step();
        out_rd = 1'b0;
    endtask

    initial begin
        int   k, c, n;
        logic who_s[4];
        time  t_s[4];

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_byte", out_byte, 0);
        chk("rst busy", busy, 0);
        chk("rst words_sent", words_sent, 0);
        chk("rst acks", {ack1, ack0}, 0);
        step();
        rst = 1'b0;
        ce = 1'b1;
        out_rd = 1'b1;

        // Single word latency and byte order
        step();
        w0q.push_back(16'hA55A);
        wait_ack(1'b0, k);
        chk("single ack0 latency", k, 2);
        @(negedge clk);
        @(negedge clk);
        chk("single low byte", out_byte, 8'h5A);
        @(negedge clk);
        chk("single high byte", out_byte, 8'hA5);
        chk("single words_sent", words_sent, 1);
        drain("single drain");

        // Both requesting continuously after reset: alternate from requester 0
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w0q.push_back(16'h0100 + 16'(i));
            w1q.push_back(16'h0200 + 16'(i));
        end
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                who_s[n] = ack1;
                t_s[n]   = $time;
                n++;
            end
        end
        chk("tie ack count", n, 4);
        for (int i = 0; i < n; i++) chk("tie alternation", who_s[i], i % 2);
        for (int i = 1; i < n; i++) chk("tie period", 32'(t_s[i] - t_s[i-1]), 30);
        drain("tie drain");

        // No pops: FIFO of 4 admits exactly 2 words until 2 bytes are popped
        step();
        out_rd = 1'b0;
        w0q.push_back(16'h1201);
        w0q.push_back(16'h3403);
        w0q.push_back(16'h5605);
        w0q.push_back(16'h7807);
        count_acks(20, 1'b0, c);
        chk("full accepted words", c, 2);
        chk("full head byte", out_byte, 8'h01);
        pulse_rd();
        count_acks(6, 1'b0, c);
        chk("full after one pop", c, 0);
        chk("full head after pop", out_byte, 8'h12);
        pulse_rd();
        count_acks(6, 1'b0, c);
        chk("full after two pops", c, 1);
        step();
        out_rd = 1'b1;
        drain("full drain");

        // ce gating of grants only
        step();
        ce = 1'b0;
        w1q.push_back(16'hBEEF);
        count_acks(6, 1'b1, c);
        chk("ce0 no ack1", c, 0);
        chk("ce0 idle", busy, 0);
        step();
        ce = 1'b1;
        wait_ack(1'b1, k);
        chk("ce1 ack1 latency", k, 2);
        ce = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ce drop low byte", out_byte, 8'hEF);
        @(negedge clk);
        chk("ce drop high byte", out_byte, 8'hBE);
        drain("ce drain");
        step();
        ce = 1'b1;

        // Reset during the gap cycle of a transfer
        w0q.push_back(16'h1234);
        wait_ack(1'b0, k);
        chk("mid rst ack0 latency", k, 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst words_sent", words_sent, 0);
        step();
        step();
        rst = 1'b0;
        w0q.push_back(16'h0A0B);
        w1q.push_back(16'h0C0D);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(ack0 || ack1) && k < 10);
        chk("post rst first grant", {ack1, ack0}, 2'b01);
        drain("post rst drain");

        // Reads on an empty FIFO are ignored
        c = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) c++;
        end
        chk("empty reads", c, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/word_tx_sched.md
WORD_TX_SCHED -- requirements
Module: word_tx_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning byte output FIFO depth (power of two, >=4).
REQ-002 SHALL have ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ce  in  1  clock enable for new grants
req0  in  1  requester 0 holds word0 valid
word0  in  16  requester 0 word
ack0  out  1  one-cycle pulse, word0 accepted
req1  in  1  requester 1 holds word1 valid
word1  in  16  requester 1 word
ack1  out  1  one-cycle pulse, word1 accepted
out_byte  out  8  FIFO head byte (first-word-fall-through)
out_valid  out  1  FIFO not empty
out_rd  in  1  pop FIFO head
busy  out  1  state!=IDLE or FIFO count!=0 or reserved!=0
words_sent  out  16  accepted-word counter, wraps 0xFFFF->0

Function
REQ-003 SHALL sequence one word_2_byte instance: drive its word_dv/word; push its byte_dv/byteee into the FIFO.
REQ-004 SHALL implement FSM IDLE, ISSUE, GAP; ISSUE->GAP and GAP->IDLE unconditionally, regardless of ce.
REQ-005 IDLE->ISSUE SHALL occur when ce=1, (req0|req1)=1 and fifo_count+reserved <= FIFO_DEPTH-2.
REQ-006 Grant SHALL be decided in IDLE: single requester wins; both requesting -> requester not in last_grant wins; last_grant updates on each grant.
REQ-007 In ISSUE SHALL assert word_dv=1, word=granted word (registered at the IDLE->ISSUE edge), and ack of the granted requester, for exactly one cycle.
REQ-008 Requester SHALL hold req and word stable until ack; after ack it may present a new word from the next cycle.
REQ-009 word_dv SHALL never assert in two cycles less than 3 apart (guaranteed by GAP).
REQ-010 Latency: req sampled at edge E0 -> ISSUE cycle C1 -> low byte pushed end of C2 -> high byte pushed end of C3; out_valid=1 with low byte from C3.
REQ-011 Byte order on out_byte SHALL be word[7:0] then word[15:8].
REQ-012 reserved counter (0..2): +2 on entering ISSUE, -1 on each FIFO push; FIFO SHALL therefore never overflow.
REQ-013 FIFO: push and pop same cycle -> count unchanged; out_rd while empty -> ignored, no state change.
REQ-014 Pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-015 words_sent SHALL increment by 1 on each ISSUE cycle.
REQ-016 ce=0 SHALL block only new grants; in-flight bytes, pushes and pops continue.

Reset
REQ-017 On rst: state=IDLE, ack0=ack1=0, word_dv=0, last_grant=1 (requester 0 wins first tie), FIFO empty, out_valid=0, out_byte=0, reserved=0, words_sent=0, busy=0.
REQ-018 Reset mid-operation SHALL discard in-flight and queued bytes; the word_2_byte instance SHALL share rst.

Structure
REQ-019 Shared package SHALL hold FSM state enum (IDLE, ISSUE, GAP) and constant DEFAULT_FIFO_DEPTH=4.
REQ-020 SHALL instantiate word_2_byte as the sole sub-module; FIFO, arbiter and FSM inline.

Verification
REQ-021 req0=1 word0=0xA55A, out_rd=1 -> ack0 at C1, out_byte 0x5A at C3, 0xA5 at C4, words_sent=1.
REQ-022 req0=req1=1 continuously, out_rd=1 -> acks alternate ack0, ack1, ack0 ...; word_dv period 3 cycles.
REQ-023 out_rd=0, FIFO_DEPTH=4, req0 held -> exactly 2 words accepted, then no ack until 2 pops.
REQ-024 ce=0 with req1=1 -> no ack1; ce=1 -> ack1 next cycle; ce dropped during ISSUE -> bytes still delivered.
REQ-025 rst asserted in cycle C2 of a transfer -> out_valid=0, busy=0, words_sent=0 immediately; next grant goes to requester 0.
REQ-026 out_rd=1 on empty FIFO and push+pop same cycle -> count correct, no spurious out_valid.
